// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Purpose  : Multi-cycle multiply/divide unit for the EX stage. Holds the
//            architectural HI/LO registers, executes MULT/MULTU/DIV/DIVU with
//            a fixed busy latency, and MTHI/MTLO with single-cycle latency.
// Ports    : clk, rst (sync, active-high)
//            start, op[2:0]      issue strobe and operation code
//            src_a, src_b [W]    rs / rt operands
//            busy                high while a mult/div is in flight
//            stall_req           busy | (start & mult/div op), for ID stall
//            done                one-cycle pulse when a mult/div commits
//            hi, lo [W]          HI/LO registers
// Revision : 1.0  initial release
// ============================================================================
module mdu_unit #(
    parameter int W           = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    output logic         busy,
    output logic         stall_req,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int c_MAXN  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W = $clog2(c_MAXN + 1);
    localparam logic [c_CNT_W-1:0] c_MULT_N = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_N  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_op;      // op[1]: divide, op[0]: unsigned
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic                 r_done;
    logic [W-1:0]         r_hi;
    logic [W-1:0]         r_lo;

    logic                 w_idle;
    logic                 w_issue;
    logic                 w_mt_hi;
    logic                 w_mt_lo;
    logic                 w_last;
    logic                 w_b_zero;
    logic                 w_commit;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign w_idle   = (r_state == S_IDLE);
    assign w_issue  = w_idle & start & ~op[2];
    assign w_mt_hi  = w_idle & start & (op == 3'd4);
    assign w_mt_lo  = w_idle & start & (op == 3'd5);
    assign w_last   = (r_state == S_BUSY) & (r_cnt == c_ONE);
    assign w_b_zero = (r_b == '0);
    // A divide by zero still runs its full latency but leaves HI/LO alone.
    assign w_commit = w_last & ~(r_op[1] & w_b_zero);

    // ------------------------------------------------------------------
    // Arithmetic on the latched operands
    // ------------------------------------------------------------------
    logic [2*W-1:0] w_a_ext;
    logic [2*W-1:0] w_b_ext;
    logic [2*W-1:0] w_prod;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [W-1:0]   w_b_div;
    logic [W-1:0]   w_q_mag;
    logic [W-1:0]   w_r_mag;
    logic [W-1:0]   w_q;
    logic [W-1:0]   w_r;
    logic [2*W-1:0] w_res;

    // Sign/zero extension to 2W makes the low 2W product bits exact for both
    // signed and unsigned operands.
    assign w_a_ext = r_op[0] ? {{W{1'b0}}, r_a} : {{W{r_a[W-1]}}, r_a};
    assign w_b_ext = r_op[0] ? {{W{1'b0}}, r_b} : {{W{r_b[W-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed division via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. The most-negative / -1 case falls
    // out naturally as quotient = most-negative, remainder = 0.
    assign w_a_neg = ~r_op[0] & r_a[W-1];
    assign w_b_neg = ~r_op[0] & r_b[W-1];
    assign w_a_mag = w_a_neg ? (~r_a + 1'b1) : r_a;
    assign w_b_mag = w_b_neg ? (~r_b + 1'b1) : r_b;
    assign w_b_div = w_b_zero ? {{(W-1){1'b0}}, 1'b1} : w_b_mag;
    assign w_q_mag = w_a_mag / w_b_div;
    assign w_r_mag = w_a_mag % w_b_div;
    assign w_q     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
    assign w_r     = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;

    assign w_res   = r_op[1] ? {w_r, w_q} : w_prod;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= w_last;

            if (w_issue) begin
                r_op  <= op[1:0];
                r_a   <= src_a;
                r_b   <= src_b;
                r_cnt <= op[1] ? c_DIV_N : c_MULT_N;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - c_ONE;
            end

            // Commit happens only in BUSY and MT writes only in IDLE, so the
            // two never collide.
            if (w_commit) begin
                r_hi <= w_res[2*W-1:W];
                r_lo <= w_res[W-1:0];
            end else begin
                if (w_mt_hi) r_hi <= src_a;
                if (w_mt_lo) r_lo <= src_a;
            end
        end
    end

    assign busy      = (r_state == S_BUSY);
    assign stall_req = busy | (start & ~op[2]);
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_unit
// Purpose  : Directed self-checking bench for mdu_unit (W=32, 5/10 cycles).
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    mdu_unit #(
        .W           (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, expected finished)");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a mult/div, scramble the sources afterwards, check busy for
    // exactly n cycles, then check done and HI/LO in the commit cycle.
    // Returns in the commit cycle with start low.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        chk({tag, " stall_req@issue"}, {31'b0, stall_req}, 32'd1);
        tick();
        start = 1'b0; src_a = $urandom; src_b = $urandom;
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, {31'b0, busy}, 32'd1);
            chk({tag, " done_low"}, {31'b0, done}, 32'd0);
            tick();
        end
        chk({tag, " busy_fall"}, {31'b0, busy}, 32'd0);
        chk({tag, " done"}, {31'b0, done}, 32'd1);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset stall", {31'b0, stall_req}, 32'd0);

        // Back-to-back: each op is issued in the previous commit cycle.
        run_op("MULT", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("MULTU", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("DIV", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("DIVU", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("DIVovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        tick();
        chk("done one cycle", {31'b0, done}, 32'd0);

        // MT writes, then divide by zero keeps HI/LO.
        start = 1'b1; op = 3'd4; src_a = 32'h11;
        #1;
        chk("MT stall_req", {31'b0, stall_req}, 32'd0);
        tick();
        op = 3'd5; src_a = 32'h22;
        tick();
        start = 1'b0;
        chk("MT setup hi", hi, 32'h11);
        chk("MT setup lo", lo, 32'h22);
        run_op("DIV0", 3'd2, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        tick();

        // Consecutive MTHI/MTLO: no busy, no done.
        start = 1'b1; op = 3'd4; src_a = 32'hABCD_0000;
        tick();
        chk("MTHI hi", hi, 32'hABCD_0000);
        chk("MTHI lo unchanged", lo, 32'h22);
        chk("MTHI busy", {31'b0, busy}, 32'd0);
        op = 3'd5; src_a = 32'h0000_1234;
        tick();
        start = 1'b0;
        chk("MTLO lo", lo, 32'h0000_1234);
        chk("MTLO hi unchanged", hi, 32'hABCD_0000);
        chk("MTLO busy", {31'b0, busy}, 32'd0);
        chk("MTLO done", {31'b0, done}, 32'd0);
        tick();
        chk("MT no done", {31'b0, done}, 32'd0);

        // Reset in busy cycle 3 discards the in-flight MULT.
        start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rstmid busy@3", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid busy", {31'b0, busy}, 32'd0);
        chk("rstmid hi", hi, 32'h0);
        chk("rstmid lo", lo, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("rstmid no done", {31'b0, done}, 32'd0);
            chk("rstmid lo stays", lo, 32'h0);
            tick();
        end

        // Start while BUSY is ignored (DIVU and MTHI both).
        start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        tick();
        op = 3'd3; src_a = 32'd9; src_b = 32'd2;
        tick();
        op = 3'd4; src_a = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        chk("ign hi", hi, 32'h0);
        chk("ign busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("ign done", {31'b0, done}, 32'd1);
        chk("ign lo", lo, 32'd14);
        chk("ign hi2", hi, 32'd2);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("ign idle busy", {31'b0, busy}, 32'd0);
            chk("ign idle done", {31'b0, done}, 32'd0);
        end
        chk("ign lo final", lo, 32'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
